regbank8_1hot: RTL and testbench

- 8-entry × WIDTH register bank.
- Sits directly downstream of the 3:8 write-address decoder and consumes its 8-bit one-hot write-select output as the per-register write enable.
- Two synchronous read ports, indexed by 3-bit addresses, feed the datapath operand latches.
- Detects illegal (non-one-hot) write selects, suppresses the write and flags the error.

---
 rtl/regbank8_1hot.sv | 121 ++++++++++++
 tb/tb_regbank8_1hot.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regbank8_1hot.sv
// regbank8_1hot: 8-entry x WIDTH register bank written through a one-hot select.
// Two registered read ports (1-cycle latency), sticky multi-hot error flag and
// an 8-bit accepted-write counter. Register 7 is hardwired to zero when
// ZERO_LAST is set.
// Optional feature: define REGBANK_BYPASS_EN to forward same-edge write data
// to a read port addressing the register being written.
module regbank8_1hot #(
    parameter int unsigned WIDTH     = 64,
    parameter bit          ZERO_LAST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [2:0]       rd_addr_a,
    input  logic [2:0]       rd_addr_b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             err_multi,
    output logic [7:0]       wr_count
);

    localparam int unsigned NREG = 8;

    logic [WIDTH-1:0] regs [NREG];

    logic             wr_one_c;
    logic             wr_multi_c;
    logic [NREG-1:0]  wr_en_c;
    logic [WIDTH-1:0] rd_next_a_c;
    logic [WIDTH-1:0] rd_next_b_c;

    // Classify the write select: clearing the lowest set bit leaves zero only for 0 or 1 bits set
    always_comb begin
        wr_one_c   = 1'b0;
        wr_multi_c = 1'b0;
        if (wr_sel != 8'd0) begin
            if ((wr_sel & (wr_sel - 8'd1)) == 8'd0) begin
                wr_one_c = 1'b1;
            end else begin
                wr_multi_c = 1'b1;
            end
        end
    end

    // Per-register write enables; the hardwired zero register never stores data
    always_comb begin
        wr_en_c = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            wr_en_c[3'(i)] = wr_one_c && wr_sel[3'(i)] && !(ZERO_LAST && (i == NREG - 1));
        end
    end

    // Next read data for both ports, including optional write forwarding
    always_comb begin
        rd_next_a_c = regs[rd_addr_a];
        rd_next_b_c = regs[rd_addr_b];
        if (ZERO_LAST && (rd_addr_a == 3'd7)) begin
            rd_next_a_c = '0;
        end
        if (ZERO_LAST && (rd_addr_b == 3'd7)) begin
            rd_next_b_c = '0;
        end
`ifdef REGBANK_BYPASS_EN
        if (wr_en_c[rd_addr_a]) begin
            rd_next_a_c = wr_data;
        end
        if (wr_en_c[rd_addr_b]) begin
            rd_next_b_c = wr_data;
        end
`endif
    end

    // Register storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[3'(i)] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (wr_en_c[3'(i)]) begin
                    regs[3'(i)] <= wr_data;
                end
            end
        end
    end

    // Registered read ports
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            rd_data_a <= rd_next_a_c;
            rd_data_b <= rd_next_b_c;
        end
    end

    // Sticky multi-hot error flag; a new error wins over a same-edge clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_multi <= 1'b0;
        end else if (wr_multi_c) begin
            err_multi <= 1'b1;
        end else if (clr_err) begin
            err_multi <= 1'b0;
        end
    end

    // Accepted-write counter, including discarded writes to the zero register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_count <= 8'd0;
        end else if (wr_one_c) begin
            wr_count <= wr_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_regbank8_1hot.sv
// tb_regbank8_1hot: directed test of regbank8_1hot against a behavioural model.
// Honours REGBANK_BYPASS_EN when compiled with it.
module tb_regbank8_1hot;

    localparam int unsigned WIDTH = 64;
    localparam bit          ZL    = 1'b1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [7:0]       wr_sel;
    logic [WIDTH-1:0] wr_data;
    logic [2:0]       rd_addr_a;
    logic [2:0]       rd_addr_b;
    logic             clr_err;
    logic [WIDTH-1:0] rd_data_a;
    logic [WIDTH-1:0] rd_data_b;
    logic             err_multi;
    logic [7:0]       wr_count;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    regbank8_1hot #(.WIDTH(WIDTH), .ZERO_LAST(ZL)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .clr_err   (clr_err),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .err_multi (err_multi),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: architectural registers plus expected output values
    logic [63:0] m_reg [8];
    logic [63:0] m_rd_a, m_rd_b;
    logic        m_err;
    int          m_cnt;

    function automatic logic [63:0] m_read(input logic [2:0] addr);
        if (ZL && addr == 3'd7) return 64'd0;
        return m_reg[addr];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) m_reg[i] = 64'd0;
            m_rd_a = 64'd0;
            m_rd_b = 64'd0;
            m_err  = 1'b0;
            m_cnt  = 0;
        end else begin
            int n;
            int widx;
            bit keep;
            n    = $countones(wr_sel);
            widx = 0;
            for (int i = 0; i < 8; i++) if (wr_sel[i]) widx = i;
            keep = (n == 1) && !(ZL && widx == 7);
            m_rd_a = m_read(rd_addr_a);
            m_rd_b = m_read(rd_addr_b);
`ifdef REGBANK_BYPASS_EN
            if (keep && int'(rd_addr_a) == widx) m_rd_a = wr_data;
            if (keep && int'(rd_addr_b) == widx) m_rd_b = wr_data;
`endif
            if (keep) m_reg[widx] = wr_data;
            if (n == 1) m_cnt = (m_cnt + 1) % 256;
            if (n >= 2) m_err = 1'b1;
            else if (clr_err) m_err = 1'b0;
        end
    end

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_rd_a", rd_data_a, m_rd_a);
            check("cmp_rd_b", rd_data_b, m_rd_b);
            check("cmp_err", 64'(err_multi), 64'(m_err));
            check("cmp_cnt", 64'(wr_count), 64'(m_cnt));
        end
    end

    task automatic wr(input logic [7:0] sel, input logic [63:0] data);
        @(negedge clk);
        wr_sel  = sel;
        wr_data = data;
    endtask

    initial begin
        logic [63:0] ones;
        ones      = '1;
        reset_n   = 1'b0;
        wr_sel    = 8'd0;
        wr_data   = '0;
        rd_addr_a = 3'd0;
        rd_addr_b = 3'd0;
        clr_err   = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        @(negedge clk);
        check("reset_rd_a", rd_data_a, 64'd0);
        check("reset_rd_b", rd_data_b, 64'd0);
        check("reset_err", 64'(err_multi), 64'd0);
        check("reset_cnt", 64'(wr_count), 64'd0);

        // Basic write then read
        wr(8'h04, 64'hDEAD_BEEF_0000_0002);
        @(negedge clk);
        wr_sel    = 8'd0;
        rd_addr_a = 3'd2;
        @(negedge clk);
        check("basic_rd_a", rd_data_a, 64'hDEAD_BEEF_0000_0002);
        check("basic_cnt", 64'(wr_count), 64'd1);

        // Multi-hot rejection and flag priority
        wr(8'h08, 64'd5);
        wr(8'h20, 64'd9);
        wr(8'h28, 64'd1);
        rd_addr_a = 3'd3;
        rd_addr_b = 3'd5;
        @(negedge clk);
        wr_sel = 8'd0;
        @(negedge clk);
        check("multi_reg3", rd_data_a, 64'd5);
        check("multi_reg5", rd_data_b, 64'd9);
        check("multi_err", 64'(err_multi), 64'd1);
        check("multi_cnt", 64'(wr_count), 64'd3);
        wr_sel  = 8'h28;
        clr_err = 1'b1;
        @(negedge clk);
        wr_sel = 8'd0;
        check("set_beats_clr", 64'(err_multi), 64'd1);
        @(negedge clk);
        clr_err = 1'b0;
        check("clr_err", 64'(err_multi), 64'd0);
        check("multi_reg3_again", rd_data_a, 64'd5);

        // Read during write on port B
        wr(8'h02, 64'd7);
        wr(8'h02, 64'd8);
        rd_addr_b = 3'd1;
        @(negedge clk);
        wr_sel = 8'd0;
`ifdef REGBANK_BYPASS_EN
        check("rdw_first", rd_data_b, 64'd8);
`else
        check("rdw_first", rd_data_b, 64'd7);
`endif
        @(negedge clk);
        check("rdw_second", rd_data_b, 64'd8);
        check("rdw_cnt", 64'(wr_count), 64'd5);

        // Hardwired zero register
        wr(8'h80, ones);
        rd_addr_a = 3'd7;
        rd_addr_b = 3'd7;
        @(negedge clk);
        wr_sel = 8'd0;
        check("zero_fwd_a", rd_data_a, 64'd0);
        check("zero_fwd_b", rd_data_b, 64'd0);
        @(negedge clk);
        check("zero_rd_a", rd_data_a, 64'd0);
        check("zero_rd_b", rd_data_b, 64'd0);
        check("zero_cnt", 64'(wr_count), 64'd6);

        // Counter wrap: 249 more writes reach 255, one more wraps to 0
        for (int k = 0; k < 249; k++) begin
            @(negedge clk);
            wr_sel    = 8'(8'h01 << (k % 8));
            wr_data   = {$urandom, $urandom};
            rd_addr_a = 3'(k % 8);
            rd_addr_b = 3'((k + 3) % 8);
        end
        @(negedge clk);
        check("cnt_255", 64'(wr_count), 64'd255);
        wr_sel = 8'h01;
        @(negedge clk);
        wr_sel = 8'd0;
        check("cnt_wrap", 64'(wr_count), 64'd0);

        // Async reset between edges
        wr(8'h04, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        wr_sel    = 8'h11;
        rd_addr_a = 3'd2;
        @(negedge clk);
        wr_sel = 8'd0;
        check("pre_reset_rd_a", rd_data_a, 64'h0123_4567_89AB_CDEF);
        check("pre_reset_err", 64'(err_multi), 64'd1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rd_a", rd_data_a, 64'd0);
        check("async_rd_b", rd_data_b, 64'd0);
        check("async_err", 64'(err_multi), 64'd0);
        check("async_cnt", 64'(wr_count), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_reset_reg2", rd_data_a, 64'd0);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
